// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// writeback-select codes and forwarding-select codes.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  localparam logic [1:0] WB_LOAD = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  function automatic logic is_load(input logic [1:0] wbsel);
    return wbsel == WB_LOAD;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: stage register ids and
// enables in, stall/flush/forward controls and status out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_ID, rs2_ID;
  logic             rs1_used_ID, rs2_used_ID;
  logic [4:0]       rs1_EX, rs2_EX;
  logic [4:0]       rsW_EX, rsW_MEM, rsW_WB;
  logic             RegWEn_EX, RegWEn_MEM, RegWEn_WB;
  logic [1:0]       WBSel_EX;
  logic             branch_taken_EX;
  logic             dmem_req_MEM;
  logic             dmem_ready;
  logic             stall_IF, stall_ID, stall_EX, stall_MEM;
  logic             flush_ID, flush_EX, flush_WB;
  logic [1:0]       fwdA_sel, fwdB_sel;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport slave (
    input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rs1_EX, rs2_EX,
           rsW_EX, rsW_MEM, rsW_WB, RegWEn_EX, RegWEn_MEM, RegWEn_WB,
           WBSel_EX, branch_taken_EX, dmem_req_MEM, dmem_ready,
    output stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX,
           flush_WB, fwdA_sel, fwdB_sel, mem_timeout, stall_cycles
  );

  modport master (
    output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rs1_EX, rs2_EX,
           rsW_EX, rsW_MEM, rsW_WB, RegWEn_EX, RegWEn_MEM, RegWEn_WB,
           WBSel_EX, branch_taken_EX, dmem_req_MEM, dmem_ready,
    input  stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX,
           flush_WB, fwdA_sel, fwdB_sel, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding select for one source operand; the younger
// MEM-stage result wins over WB, and x0 is never forwarded.
module fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_rs_EX,
  input  logic [4:0] i_rsW_MEM,
  input  logic       i_RegWEn_MEM,
  input  logic [4:0] i_rsW_WB,
  input  logic       i_RegWEn_WB,
  output logic [1:0] o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_RegWEn_MEM && (i_rsW_MEM != 5'd0) && (i_rsW_MEM == i_rs_EX))
      o_sel = FWD_MEM;
    else if (i_RegWEn_WB && (i_rsW_WB != 5'd0) && (i_rsW_WB == i_rs_EX))
      o_sel = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: stall/flush priority,
// operand forwarding, dmem wait-state FSM with timeout and stall counter.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUN      | normal flow; first dmem wait cycle is still seen here
// ST_MEM_WAIT | dmem access outstanding, wait_cnt counts wait cycles
// ST_ERR      | dmem timed out; pipeline frozen until reset
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           r_state;
  logic [7:0]       r_wait_cnt;
  logic             r_mem_timeout;
  logic [CNT_W-1:0] r_stall_cycles;

  logic       w_mem_wait, w_mem_stall, w_lu, w_any_stall;
  logic [1:0] w_fwdA, w_fwdB;

  assign w_mem_wait  = bus.dmem_req_MEM & ~bus.dmem_ready;
  assign w_mem_stall = w_mem_wait | (r_state == ST_ERR);

  assign w_lu = bus.RegWEn_EX & is_load(bus.WBSel_EX) & (bus.rsW_EX != 5'd0) &
                ((bus.rs1_used_ID & (bus.rs1_ID == bus.rsW_EX)) |
                 (bus.rs2_used_ID & (bus.rs2_ID == bus.rsW_EX)));

  // A taken branch makes the dependent ID instruction wrong-path, so no lu stall.
  assign w_any_stall = w_mem_stall | (w_lu & ~bus.branch_taken_EX);

  fwd_unit u_fwd_a (
    .i_rs_EX      (bus.rs1_EX),
    .i_rsW_MEM    (bus.rsW_MEM),
    .i_RegWEn_MEM (bus.RegWEn_MEM),
    .i_rsW_WB     (bus.rsW_WB),
    .i_RegWEn_WB  (bus.RegWEn_WB),
    .o_sel        (w_fwdA)
  );

  fwd_unit u_fwd_b (
    .i_rs_EX      (bus.rs2_EX),
    .i_rsW_MEM    (bus.rsW_MEM),
    .i_RegWEn_MEM (bus.RegWEn_MEM),
    .i_rsW_WB     (bus.rsW_WB),
    .i_RegWEn_WB  (bus.RegWEn_WB),
    .o_sel        (w_fwdB)
  );

  always_comb begin
    bus.stall_IF  = 1'b0;
    bus.stall_ID  = 1'b0;
    bus.stall_EX  = 1'b0;
    bus.stall_MEM = 1'b0;
    bus.flush_ID  = 1'b0;
    bus.flush_EX  = 1'b0;
    bus.flush_WB  = 1'b0;
    bus.fwdA_sel  = FWD_RF;
    bus.fwdB_sel  = FWD_RF;
    if (!reset) begin
      bus.flush_ID = 1'b1;
      bus.flush_EX = 1'b1;
      bus.flush_WB = 1'b1;
    end else begin
      bus.fwdA_sel = w_fwdA;
      bus.fwdB_sel = w_fwdB;
      if (w_mem_stall) begin
        bus.stall_IF  = 1'b1;
        bus.stall_ID  = 1'b1;
        bus.stall_EX  = 1'b1;
        bus.stall_MEM = 1'b1;
        bus.flush_WB  = 1'b1;
      end else if (bus.branch_taken_EX) begin
        bus.flush_ID = 1'b1;
        bus.flush_EX = 1'b1;
      end else if (w_lu) begin
        bus.stall_IF = 1'b1;
        bus.stall_ID = 1'b1;
        bus.flush_EX = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= 8'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_wait) begin
            if (r_wait_cnt == TO_LAST) begin
              r_state       <= ST_ERR;
              r_mem_timeout <= 1'b1;
            end else begin
              r_state    <= ST_MEM_WAIT;
              r_wait_cnt <= r_wait_cnt + 8'd1;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (bus.dmem_ready) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
          end else if (r_wait_cnt == TO_LAST) begin
            r_state       <= ST_ERR;
            r_mem_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        ST_ERR:  r_state <= ST_ERR;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_stall_cycles <= '0;
    else if (w_any_stall && (r_stall_cycles != {CNT_W{1'b1}}))
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
  end

  assign bus.mem_timeout  = r_mem_timeout;
  assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a short timeout and a 4-bit
// stall counter so timeout and saturation are reachable quickly.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_mis;

  pipe_hazard_ctrl_if #(.CNT_W(4)) bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.rs1_ID = 5'd0;  bus.rs2_ID = 5'd0;
    bus.rs1_used_ID = 1'b0;  bus.rs2_used_ID = 1'b0;
    bus.rs1_EX = 5'd0;  bus.rs2_EX = 5'd0;
    bus.rsW_EX = 5'd0;  bus.rsW_MEM = 5'd0;  bus.rsW_WB = 5'd0;
    bus.RegWEn_EX = 1'b0;  bus.RegWEn_MEM = 1'b0;  bus.RegWEn_WB = 1'b0;
    bus.WBSel_EX = 2'b01;
    bus.branch_taken_EX = 1'b0;
    bus.dmem_req_MEM = 1'b0;
    bus.dmem_ready = 1'b0;
  endtask

  // {stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, flush_WB}
  function automatic logic [6:0] ctl();
    return {bus.stall_IF, bus.stall_ID, bus.stall_EX, bus.stall_MEM,
            bus.flush_ID, bus.flush_EX, bus.flush_WB};
  endfunction

  task automatic set_lu_rs1();
    bus.RegWEn_EX = 1'b1;  bus.WBSel_EX = 2'b00;  bus.rsW_EX = 5'd5;
    bus.rs1_ID = 5'd5;  bus.rs1_used_ID = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    reset = 1'b0;
    clear_inputs();
    // forwarding match present while in reset must still read as RF
    bus.RegWEn_MEM = 1'b1;  bus.rsW_MEM = 5'd7;  bus.rs1_EX = 5'd7;
    #3;
    chk("reset_ctl",      32'(ctl()), 32'b0000_111);
    chk("reset_fwdA",     32'(bus.fwdA_sel), 32'd0);
    chk("reset_fwdB",     32'(bus.fwdB_sel), 32'd0);
    chk("reset_cnt",      32'(bus.stall_cycles), 32'd0);
    chk("reset_timeout",  32'(bus.mem_timeout), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    tick();

    #2 chk("idle_ctl", 32'(ctl()), 32'b0000_000);
    tick();

    // load-use on rs1: one stall cycle
    set_lu_rs1();
    #2 chk("lu_rs1_ctl", 32'(ctl()), 32'b1100_010);
    tick();
    clear_inputs();
    #2 chk("lu_after_ctl", 32'(ctl()), 32'b0000_000);
    chk("lu_after_cnt", 32'(bus.stall_cycles), 32'd1);
    tick();

    // load-use on rs2
    bus.RegWEn_EX = 1'b1;  bus.WBSel_EX = 2'b00;  bus.rsW_EX = 5'd9;
    bus.rs2_ID = 5'd9;  bus.rs2_used_ID = 1'b1;
    #2 chk("lu_rs2_ctl", 32'(ctl()), 32'b1100_010);
    tick();
    bus.WBSel_EX = 2'b01;
    #2 chk("alu_no_lu_ctl", 32'(ctl()), 32'b0000_000);
    tick();
    bus.WBSel_EX = 2'b00;  bus.rs2_used_ID = 1'b0;
    #2 chk("unused_rs_ctl", 32'(ctl()), 32'b0000_000);
    tick();
    clear_inputs();
    bus.RegWEn_EX = 1'b1;  bus.WBSel_EX = 2'b00;  bus.rsW_EX = 5'd0;
    bus.rs1_used_ID = 1'b1;  bus.rs1_ID = 5'd0;
    #2 chk("x0_no_lu_ctl", 32'(ctl()), 32'b0000_000);
    tick();

    // branch overrides load-use
    clear_inputs();
    set_lu_rs1();
    bus.branch_taken_EX = 1'b1;
    #2 chk("br_over_lu_ctl", 32'(ctl()), 32'b0000_110);
    tick();
    clear_inputs();
    #2 chk("br_cnt", 32'(bus.stall_cycles), 32'd2);

    // forwarding
    bus.RegWEn_MEM = 1'b1;  bus.RegWEn_WB = 1'b1;
    bus.rsW_MEM = 5'd7;  bus.rsW_WB = 5'd7;  bus.rs1_EX = 5'd7;  bus.rs2_EX = 5'd7;
    #1 chk("fwdA_mem", 32'(bus.fwdA_sel), 32'd1);
    chk("fwdB_mem", 32'(bus.fwdB_sel), 32'd1);
    chk("fwd_no_stall", 32'(ctl()), 32'b0000_000);
    bus.rsW_MEM = 5'd0;
    #1 chk("fwdA_wb", 32'(bus.fwdA_sel), 32'd2);
    bus.rs1_EX = 5'd0;  bus.rsW_WB = 5'd0;
    #1 chk("fwdA_x0", 32'(bus.fwdA_sel), 32'd0);
    bus.rs2_EX = 5'd3;  bus.rsW_MEM = 5'd3;  bus.RegWEn_MEM = 1'b0;  bus.rsW_WB = 5'd3;
    #1 chk("fwdB_wb_mem_off", 32'(bus.fwdB_sel), 32'd2);
    bus.RegWEn_WB = 1'b0;
    #1 chk("fwdB_rf", 32'(bus.fwdB_sel), 32'd0);
    tick();

    // memory wait of 3 cycles, with a branch held across it
    reset = 1'b0;
    #2 reset = 1'b1;
    clear_inputs();
    bus.dmem_req_MEM = 1'b1;  bus.branch_taken_EX = 1'b1;
    set_lu_rs1();
    for (int i = 0; i < 3; i++) begin
      #2 chk("memwait_ctl", 32'(ctl()), 32'b1111_001);
      tick();
    end
    bus.dmem_ready = 1'b1;
    #2 chk("memdone_ctl", 32'(ctl()), 32'b0000_110);
    chk("memdone_cnt", 32'(bus.stall_cycles), 32'd3);
    tick();
    clear_inputs();
    #2 chk("run_after_wait", 32'(ctl()), 32'b0000_000);
    tick();

    // timeout after 4 consecutive wait cycles
    bus.dmem_req_MEM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2 chk("to_pending", 32'(bus.mem_timeout), 32'd0);
      tick();
    end
    chk("to_set", 32'(bus.mem_timeout), 32'd1);
    chk("to_cnt", 32'(bus.stall_cycles), 32'd7);
    bus.dmem_req_MEM = 1'b0;  bus.dmem_ready = 1'b1;  bus.branch_taken_EX = 1'b1;
    #2 chk("err_ctl", 32'(ctl()), 32'b1111_001);
    for (int i = 0; i < 10; i++) tick();
    chk("cnt_saturate", 32'(bus.stall_cycles), 32'd15);
    chk("to_sticky", 32'(bus.mem_timeout), 32'd1);
    chk("err_persist", 32'(ctl()), 32'b1111_001);

    // asynchronous reset from ERR
    #1 reset = 1'b0;
    #1;
    chk("areset_timeout", 32'(bus.mem_timeout), 32'd0);
    chk("areset_cnt", 32'(bus.stall_cycles), 32'd0);
    chk("areset_ctl", 32'(ctl()), 32'b0000_111);
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    #1 chk("post_reset_run", 32'(ctl()), 32'b0000_000);
    tick();
    chk("post_reset_timeout", 32'(bus.mem_timeout), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
